// File: rtl/sparc_ifu_thrsched_pkg.sv
// Shared definitions for the IFU thread scheduler: per-thread state encoding and defaults.
package sparc_ifu_thrsched_pkg;

  typedef enum logic [1:0] {
    THR_DEAD = 2'b00,
    THR_RDY  = 2'b01,
    THR_RUN  = 2'b10,
    THR_WAIT = 2'b11
  } thr_state_e;

  localparam int unsigned NthrDef    = 4;
  localparam int unsigned QuantumDef = 8;
  localparam int unsigned AgeMaxDef  = 32;
  // Age counters are 6 bits wide, enough for AgeMax up to 63.
  localparam int unsigned AgeW       = 6;

endpackage

// File: rtl/sparc_ifu_rrpick.sv
// Round-robin one-hot picker: first requester found scanning upward from ptr_i+1 (mod Nthr).
module sparc_ifu_rrpick #(
  parameter int unsigned Nthr = 4,
  localparam int unsigned IdxW = (Nthr > 1) ? $clog2(Nthr) : 1
) (
  input  logic [Nthr-1:0] req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [Nthr-1:0] gnt_o,
  output logic [IdxW-1:0] gnt_idx_o
);

  int unsigned idx;
  logic        found;

  // Scan Nthr positions after the pointer; the pointer's own slot is visited last.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned k = 1; k <= Nthr; k++) begin
      idx = (32'(ptr_i) + k) % Nthr;
      if (!found && req_i[idx[IdxW-1:0]]) begin
        found                  = 1'b1;
        gnt_o[idx[IdxW-1:0]]   = 1'b1;
        gnt_idx_o              = idx[IdxW-1:0];
      end
    end
  end

endmodule

// File: rtl/sparc_ifu_thrsched.sv
// IFU per-thread scheduling state tracker with round-robin next-thread picker and
// quantum-based time slicing. Optional feature macro SPARC_IFU_THRSCHED_AGE_EN adds per-thread
// RDY age counters that force a pick of a starved thread once it reaches AgeMax.
module sparc_ifu_thrsched
  import sparc_ifu_thrsched_pkg::*;
#(
  parameter int unsigned Nthr    = NthrDef,
  parameter int unsigned Quantum = QuantumDef
`ifdef SPARC_IFU_THRSCHED_AGE_EN
  ,
  parameter int unsigned AgeMax  = AgeMaxDef
`endif
) (
  input  logic            clk_i,
  input  logic            rst_l_i,
  input  logic [Nthr-1:0] thr_active_i,
  input  logic [Nthr-1:0] thr_wait_s_i,
  input  logic [Nthr-1:0] completion_i,
  input  logic            sel_accept_i,
  output logic [Nthr-1:0] thr_sel_o,
  output logic            sel_vld_o,
  output logic [Nthr-1:0] thr_run_o,
  output logic [Nthr-1:0] thr_rdy_o,
  output logic [Nthr-1:0] thr_wait_o,
  output logic            switch_req_o
);

  localparam int unsigned IdxW = (Nthr > 1) ? $clog2(Nthr) : 1;
  localparam int unsigned CntW = $clog2(Quantum);

  thr_state_e      st_q [Nthr];
  thr_state_e      st_d [Nthr];
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [Nthr-1:0] run_q, rdy_q, wait_q, run_d;
  logic [Nthr-1:0] rr_gnt, sel;
  logic [IdxW-1:0] rr_idx, sel_idx;
  logic            age_ovr;
  logic            fire;

  // Decode registered per-thread state into one-hot/bit vectors.
  always_comb begin
    run_q  = '0;
    rdy_q  = '0;
    wait_q = '0;
    for (int i = 0; i < Nthr; i++) begin
      run_q[i]  = (st_q[i] == THR_RUN);
      rdy_q[i]  = (st_q[i] == THR_RDY);
      wait_q[i] = (st_q[i] == THR_WAIT);
    end
  end

  sparc_ifu_rrpick #(
    .Nthr (Nthr)
  ) u_rrpick (
    .req_i     (rdy_q),
    .ptr_i     (ptr_q),
    .gnt_o     (rr_gnt),
    .gnt_idx_o (rr_idx)
  );

`ifdef SPARC_IFU_THRSCHED_AGE_EN
  logic [AgeW-1:0] age_q [Nthr];
  logic [AgeW-1:0] age_d [Nthr];
  logic [Nthr-1:0] aged;
  logic [Nthr-1:0] aged_gnt;
  logic [IdxW-1:0] aged_idx;

  // Lowest-index thread that has sat in RDY for AgeMax cycles overrides round-robin.
  always_comb begin
    aged     = '0;
    aged_gnt = '0;
    aged_idx = '0;
    for (int i = Nthr - 1; i >= 0; i--) begin
      aged[i] = rdy_q[i] && (age_q[i] == AgeW'(AgeMax));
      if (aged[i]) begin
        aged_gnt    = '0;
        aged_gnt[i] = 1'b1;
        aged_idx    = IdxW'(i);
      end
    end
    age_ovr = |aged;
    sel     = age_ovr ? aged_gnt : rr_gnt;
    sel_idx = age_ovr ? aged_idx : rr_idx;
  end

  // Age counts only consecutive RDY cycles; any other state (or fresh entry) restarts at 0.
  always_comb begin
    for (int i = 0; i < Nthr; i++) begin
      age_d[i] = '0;
      if (st_d[i] == THR_RDY && st_q[i] == THR_RDY) begin
        age_d[i] = (age_q[i] == AgeW'(AgeMax)) ? age_q[i] : age_q[i] + AgeW'(1);
      end
    end
  end

  // Age counter registers.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < Nthr; i++) begin
      if (!rst_l_i) age_q[i] <= '0;
      else          age_q[i] <= age_d[i];
    end
  end
`else
  // Pure round-robin selection.
  always_comb begin
    sel     = rr_gnt;
    sel_idx = rr_idx;
    age_ovr = 1'b0;
  end
`endif

  assign fire = sel_accept_i & (|sel);

  // Per-thread next state, pointer and quantum counter.
  always_comb begin
    run_d = '0;
    for (int i = 0; i < Nthr; i++) begin
      st_d[i] = st_q[i];
      if (!thr_active_i[i]) begin
        st_d[i] = THR_DEAD;
      end else begin
        unique case (st_q[i])
          THR_DEAD: st_d[i] = THR_RDY;
          THR_WAIT: if (completion_i[i]) st_d[i] = THR_RDY;
          THR_RUN: begin
            // Completion arriving with the switch-out means the wait is already over.
            if (thr_wait_s_i[i])  st_d[i] = completion_i[i] ? THR_RDY : THR_WAIT;
            else if (fire && !sel[i]) st_d[i] = THR_RDY;
          end
          THR_RDY: if (fire && sel[i]) st_d[i] = THR_RUN;
          default: st_d[i] = THR_DEAD;
        endcase
      end
      run_d[i] = (st_d[i] == THR_RUN);
    end

    if (run_d == '0 || run_d != run_q) begin
      cnt_d = '0;
    end else if (cnt_q != CntW'(Quantum - 1)) begin
      cnt_d = cnt_q + CntW'(1);
    end else begin
      cnt_d = cnt_q;
    end

    ptr_d = fire ? sel_idx : ptr_q;
  end

  // State, pointer and counter registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_l_i) begin
      for (int i = 0; i < Nthr; i++) st_q[i] <= THR_DEAD;
      ptr_q <= IdxW'(Nthr - 1);
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < Nthr; i++) st_q[i] <= st_d[i];
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Outputs are purely combinational from registered state.
  always_comb begin
    thr_sel_o    = sel;
    sel_vld_o    = |sel;
    thr_run_o    = run_q;
    thr_rdy_o    = rdy_q;
    thr_wait_o   = wait_q;
    switch_req_o = (|rdy_q) & ((run_q == '0) | (cnt_q == CntW'(Quantum - 1)) | age_ovr);
  end

endmodule
